// File: rtl/elink_tx_arbiter.sv
// N-channel elink transmit arbiter: per-channel FIFOs merged onto one
// registered output by fixed-priority or round-robin selection.
module elink_tx_arbiter #(
    parameter int NCH   = 3,
    parameter int PW    = 104,
    parameter int DEPTH = 4,
    parameter int MODE  = 0,
    localparam int CW   = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic              clkin,
    input  logic              resetb,
    input  logic [NCH-1:0]    ch_access,
    input  logic [NCH*PW-1:0] ch_packet,
    output logic [NCH-1:0]    ch_wait,
    output logic              out_access,
    output logic [PW-1:0]     out_packet,
    input  logic              out_wait,
    output logic [CW-1:0]     out_grant,
    output logic [NCH-1:0]    ovf_flag,
    input  logic              ovf_clear
);

    localparam int AW = $clog2(DEPTH);

    logic [PW-1:0]  mem    [NCH][DEPTH];
    logic [AW-1:0]  wr_ptr [NCH];
    logic [AW-1:0]  rd_ptr [NCH];
    logic [AW:0]    count  [NCH];

    logic [NCH-1:0] full;
    logic [NCH-1:0] empty_n;
    logic [NCH-1:0] push;
    logic [NCH-1:0] pop;
    logic [NCH-1:0] ovf_set;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  start;
    logic [CW-1:0]  gnt;
    logic [CW:0]    idx;
    logic [CW:0]    nxt;
    logic           any;
    logic           load;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            full[i]    = (count[i] == (AW+1)'(DEPTH));
            empty_n[i] = (count[i] != '0);
        end
    end

    assign ch_wait = full;
    assign push    = ch_access & ~full;
    assign ovf_set = ch_access & full;
    assign load    = !out_access || !out_wait;

    // Search non-empty channels from start, wrapping modulo NCH
    always_comb begin
        start = (MODE == 1) ? rr_ptr : '0;
        gnt   = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = {1'b0, start} + (CW+1)'(k);
            if (idx >= (CW+1)'(NCH))
                idx = idx - (CW+1)'(NCH);
            if (!any && empty_n[idx[CW-1:0]]) begin
                any = 1'b1;
                gnt = idx[CW-1:0];
            end
        end
    end

    always_comb begin
        pop = '0;
        if (load && any)
            pop = NCH'(1) << gnt;
        nxt = {1'b0, gnt} + (CW+1)'(1);
        if (nxt == (CW+1)'(NCH))
            nxt = '0;
    end

    always_ff @(posedge clkin) begin
        for (int i = 0; i < NCH; i++)
            if (push[i])
                mem[i][wr_ptr[i]] <= ch_packet[i*PW +: PW];
    end

    always_ff @(posedge clkin or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + (AW+1)'(1);
                    2'b01:   count[i] <= count[i] - (AW+1)'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    always_ff @(posedge clkin or negedge resetb) begin
        if (!resetb) begin
            out_access <= 1'b0;
            out_packet <= '0;
            out_grant  <= '0;
            rr_ptr     <= '0;
        end else if (load) begin
            if (any) begin
                out_access <= 1'b1;
                out_packet <= mem[gnt][rd_ptr[gnt]];
                out_grant  <= gnt;
                rr_ptr     <= nxt[CW-1:0];
            end else begin
                out_access <= 1'b0;
            end
        end
    end

    // A coincident overflow outranks the clear
    always_ff @(posedge clkin or negedge resetb) begin
        if (!resetb)
            ovf_flag <= '0;
        else
            ovf_flag <= (ovf_clear ? '0 : ovf_flag) | ovf_set;
    end

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// Self-checking bench: fixed-priority and round-robin instances driven
// together and compared against a queue-based reference model.
module tb_elink_tx_arbiter;

    localparam int NCH   = 3;
    localparam int PW    = 104;
    localparam int DEPTH = 4;

    logic              clkin = 1'b0;
    logic              resetb = 1'b0;
    logic [NCH-1:0]    ch_access = '0;
    logic [NCH*PW-1:0] ch_packet = '0;
    logic              out_wait = 1'b0;
    logic              ovf_clear = 1'b0;

    logic [NCH-1:0] cw0, cw1, ovf0, ovf1;
    logic           oa0, oa1;
    logic [PW-1:0]  op0, op1;
    logic [1:0]     og0, og1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [PW-1:0]  mq [2*NCH][$];
    logic           m_oa  [2];
    logic [PW-1:0]  m_op  [2];
    int             m_og  [2];
    int             m_ptr [2];
    logic [NCH-1:0] m_ovf [2];

    always #5 clkin = ~clkin;

    elink_tx_arbiter #(.NCH(NCH), .PW(PW), .DEPTH(DEPTH), .MODE(0)) u_fp (
        .clkin(clkin), .resetb(resetb),
        .ch_access(ch_access), .ch_packet(ch_packet), .ch_wait(cw0),
        .out_access(oa0), .out_packet(op0), .out_wait(out_wait),
        .out_grant(og0), .ovf_flag(ovf0), .ovf_clear(ovf_clear)
    );

    elink_tx_arbiter #(.NCH(NCH), .PW(PW), .DEPTH(DEPTH), .MODE(1)) u_rr (
        .clkin(clkin), .resetb(resetb),
        .ch_access(ch_access), .ch_packet(ch_packet), .ch_wait(cw1),
        .out_access(oa1), .out_packet(op1), .out_wait(out_wait),
        .out_grant(og1), .ovf_flag(ovf1), .ovf_clear(ovf_clear)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int q = 0; q < 2*NCH; q++) mq[q].delete();
        for (int m = 0; m < 2; m++) begin
            m_oa[m] = 1'b0; m_op[m] = '0; m_og[m] = 0;
            m_ptr[m] = 0;   m_ovf[m] = '0;
        end
    endtask

    // One clock edge of the arbiter, from the rules, given current inputs
    task automatic model_step(input int m);
        logic [NCH-1:0] full, set;
        int found, c, start;
        for (int i = 0; i < NCH; i++)
            full[i] = (mq[m*NCH+i].size() == DEPTH);
        if (!m_oa[m] || !out_wait) begin
            found = -1;
            start = (m == 1) ? m_ptr[m] : 0;
            for (int k = 0; k < NCH; k++) begin
                c = (start + k) % NCH;
                if (found < 0 && mq[m*NCH+c].size() > 0) found = c;
            end
            if (found >= 0) begin
                m_op[m]  = mq[m*NCH+found].pop_front();
                m_oa[m]  = 1'b1;
                m_og[m]  = found;
                m_ptr[m] = (found + 1) % NCH;
            end else begin
                m_oa[m] = 1'b0;
            end
        end
        set = '0;
        for (int i = 0; i < NCH; i++)
            if (ch_access[i]) begin
                if (full[i]) set[i] = 1'b1;
                else mq[m*NCH+i].push_back(ch_packet[i*PW +: PW]);
            end
        if (ovf_clear) m_ovf[m] = '0;
        m_ovf[m] = m_ovf[m] | set;
    endtask

    task automatic check_all();
        logic [NCH-1:0] ef;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NCH; i++)
                ef[i] = (mq[m*NCH+i].size() == DEPTH);
            chk($sformatf("m%0d_access", m), m ? oa1 : oa0, m_oa[m]);
            chk($sformatf("m%0d_packet", m), m ? op1 : op0, m_op[m]);
            chk($sformatf("m%0d_grant", m), m ? og1 : og0, 128'(m_og[m]));
            chk($sformatf("m%0d_wait", m), m ? cw1 : cw0, ef);
            chk($sformatf("m%0d_ovf", m), m ? ovf1 : ovf0, m_ovf[m]);
        end
    endtask

    task automatic drv(input logic [NCH-1:0] acc, input logic [PW-1:0] p0,
                       input logic [PW-1:0] p1, input logic [PW-1:0] p2,
                       input logic ow, input logic clr);
        ch_access = acc;
        ch_packet = {p2, p1, p0};
        out_wait  = ow;
        ovf_clear = clr;
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        @(posedge clkin);
        #1;
        check_all();
    endtask

    function automatic logic [PW-1:0] rnd_pkt();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clkin);
        #1;
        check_all();
        resetb = 1'b1;

        // Reset mid-operation
        drv(3'b001, 'h1, 0, 0, 1'b1, 1'b0); step();
        drv(3'b001, 'h2, 0, 0, 1'b1, 1'b0); step();
        resetb = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clkin);
        #1;
        resetb = 1'b1;
        drv(3'b010, 0, 'hA5, 0, 1'b0, 1'b0); step();
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0); step();
        chk("rst_then_a5", op0, 'hA5);
        chk("rst_then_grant", og0, 1);
        step();

        // Single-channel streaming
        for (int v = 1; v <= 8; v++) begin
            drv(3'b100, 0, 0, PW'(v), 1'b0, 1'b0);
            step();
            if (v >= 2) begin
                chk("stream_pkt", op0, v - 1);
                chk("stream_grant", og0, 2);
            end
        end
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0); step();
        chk("stream_last", op0, 8);
        repeat (2) step();

        // Priority order: fixed vs round-robin
        drv(3'b111, 10, 20, 30, 1'b1, 1'b0); step();
        drv(3'b001, 11, 0, 0, 1'b1, 1'b0); step();
        chk("prio0_fp", op0, 10);
        chk("prio0_rr", op1, 10);
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0); step();
        chk("prio1_fp", op0, 11);
        chk("prio1_rr", op1, 20);
        step();
        chk("prio2_fp", op0, 20);
        chk("prio2_rr", op1, 30);
        step();
        chk("prio3_fp", op0, 30);
        chk("prio3_rr", op1, 11);
        step();
        chk("prio_idle", oa0, 0);

        // Full FIFO and overflow
        for (int k = 0; k < 6; k++) begin
            drv(3'b010, 0, PW'(100 + k), 0, 1'b1, 1'b0);
            step();
            if (k == 4) chk("full_wait", cw0[1], 1);
            if (k == 5) chk("ovf_set", ovf0[1], 1);
        end
        drv(3'b010, 0, 'h77, 0, 1'b1, 1'b1); step();
        chk("ovf_set_wins", ovf1[1], 1);
        drv(3'b000, 0, 0, 0, 1'b1, 1'b1); step();
        chk("ovf_cleared", ovf0, 0);
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0);
        repeat (7) step();

        // Backpressure hold
        drv(3'b001, 'h55, 0, 0, 1'b0, 1'b0); step();
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0); step();
        chk("hold_load", op0, 'h55);
        for (int k = 0; k < 3; k++) begin
            drv(3'b001, PW'('h66 + k), 0, 0, 1'b1, 1'b0);
            step();
            chk("hold_pkt", op0, 'h55);
            chk("hold_grant", og0, 0);
        end
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0); step();
        chk("hold_next", op0, 'h66);
        repeat (4) step();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drv(3'($urandom), rnd_pkt(), rnd_pkt(), rnd_pkt(),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            step();
        end
        drv(3'b000, 0, 0, 0, 1'b0, 1'b0);
        repeat (16) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
